// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock through a single add-3 bank.
// Optional BIN2BCD_SIGNED_EN: two's-complement input, magnitude converted, extra registered sign output.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                  sign
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    sreg;
    logic [WIDTH-1:0]    sreg_nxt;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] scratch_nxt;
    logic                ovf_bit;
    logic                sticky;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    operand;

`ifdef BIN2BCD_SIGNED_EN
    logic neg;
    // Negation is modulo 2**WIDTH, so the most negative value maps to its correct magnitude.
    assign operand = bin[WIDTH-1] ? (~bin + 1'b1) : bin;
`else
    assign operand = bin;
`endif

    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
        // The bit falling off the top digit is weight 10**DIGITS: it marks overflow.
        {ovf_bit, scratch_nxt, sreg_nxt} = {adj, sreg, 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            scratch  <= '0;
            sreg     <= '0;
            sticky   <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
            neg      <= 1'b0;
            sign     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sreg    <= operand;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CNT_W'(WIDTH);
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
                        neg     <= bin[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    sreg    <= sreg_nxt;
                    sticky  <= sticky | ovf_bit;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        bcd      <= scratch_nxt;
                        overflow <= sticky | ovf_bit;
                        done     <= 1'b1;
                        state    <= DONE;
                        busy     <= 1'b0;
                        ready    <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
                        sign     <= neg;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 3-digit and a 2-digit instance, expected results queued at launch.
module tb_bin2bcd_seq;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        logic        sgn;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2;
    logic [7:0]  bin1, bin2;
    logic        ready1, busy1, done1, ovf1;
    logic        ready2, busy2, done2, ovf2;
    logic [11:0] bcd1;
    logic [7:0]  bcd2;
    logic        sign1, sign2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bin(bin1),
        .ready(ready1), .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1)
`ifdef BIN2BCD_SIGNED_EN
        , .sign(sign1)
`endif
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .ready(ready2), .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
`ifdef BIN2BCD_SIGNED_EN
        , .sign(sign2)
`endif
    );

`ifndef BIN2BCD_SIGNED_EN
    assign sign1 = 1'b0;
    assign sign2 = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: decimal digits by division, accept edge e -> done visible after edge e+8.
    function automatic exp_t model(input logic [7:0] v, input int digits, input int e);
        exp_t r;
        int   mag;
        mag   = int'(v);
        r.sgn = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
        if (v[7]) begin
            mag   = 256 - int'(v);
            r.sgn = 1'b1;
        end
`endif
        r.ovf = (mag >= 10 ** digits);
        r.bcd = '0;
        for (int i = 0; i < digits; i++) begin
            r.bcd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        r.cyc = e + 8;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go1(input logic [7:0] v);
        start1 = 1'b1;
        bin1   = v;
        q1.push_back(model(v, 3, cyc + 1));
    endtask

    task automatic go2(input logic [7:0] v);
        start2 = 1'b1;
        bin2   = v;
        q2.push_back(model(v, 2, cyc + 1));
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q1.size() > 0 || q2.size() > 0); i++)
            tick(1);
        tick(1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    check("d1_spurious_done", done1, 1'b0);
                end else begin
                    e = q1.pop_front();
                    check("d1_bcd", bcd1, e.bcd);
                    check("d1_ovf", ovf1, e.ovf);
                    check("d1_sign", sign1, e.sgn);
                    check("d1_done_cycle", cyc, e.cyc);
                    check("d1_ready_at_done", ready1, 1'b1);
                end
            end else if (q1.size() > 0 && cyc > q1[0].cyc) begin
                check("d1_done_missing", done1, 1'b1);
                void'(q1.pop_front());
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    check("d2_spurious_done", done2, 1'b0);
                end else begin
                    e = q2.pop_front();
                    check("d2_bcd", {4'h0, bcd2}, e.bcd);
                    check("d2_ovf", ovf2, e.ovf);
                    check("d2_sign", sign2, e.sgn);
                    check("d2_done_cycle", cyc, e.cyc);
                end
            end else if (q2.size() > 0 && cyc > q2[0].cyc) begin
                check("d2_done_missing", done2, 1'b1);
                void'(q2.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; bin1 = '0; bin2 = '0;
        tick(2);
        check("rst_bcd", bcd1, 12'h000);
        check("rst_ovf", ovf1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_ready", ready1, 1'b1);
        check("rst_sign", sign1, 1'b0);
        rst = 1'b0;
        tick(1);

        // Single conversion of 255, ready low while shifting, bin changes ignored
        go1(8'd255);
        tick(1);
        start1 = 1'b0;
        bin1   = 8'hAA;
        check("shift_ready", ready1, 1'b0);
        check("shift_busy", busy1, 1'b1);
        tick(4);
        check("shift_ready_mid", ready1, 1'b0);
        drain();

        // Back-to-back with start held high: done pulses 9 cycles apart
        go1(8'd0);
        tick(9);
        go1(8'd9);
        tick(9);
        go1(8'd100);
        tick(1);
        start1 = 1'b0;
        drain();

        // start during SHIFT ignored
        go1(8'd37);
        tick(1);
        start1 = 1'b0;
        tick(2);
        start1 = 1'b1;
        bin1   = 8'd200;
        tick(1);
        start1 = 1'b0;
        drain();
        tick(3);

        // Two-digit overflow and its boundary
        go2(8'd123);
        tick(1);
        start2 = 1'b0;
        drain();
        go2(8'd99);
        tick(1);
        start2 = 1'b0;
        drain();
        go2(8'd100);
        tick(1);
        start2 = 1'b0;
        drain();

        // Reset mid-conversion aborts with no done
        go1(8'd180);
        tick(1);
        start1 = 1'b0;
        tick(3);
        rst = 1'b1;
        q1.delete();
        tick(1);
        check("abort_bcd", bcd1, 12'h000);
        check("abort_ready", ready1, 1'b1);
        check("abort_busy", busy1, 1'b0);
        check("abort_done", done1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("abort_no_done", done1, 1'b0);
        end
        go1(8'd180);
        tick(1);
        start1 = 1'b0;
        drain();

        // Sign-sensitive values (unsigned interpretation when the feature is off)
        go1(8'h80); tick(1); start1 = 1'b0; drain();
        go1(8'hFF); tick(1); start1 = 1'b0; drain();
        go1(8'd127); tick(1); start1 = 1'b0; drain();

        // Random operands on both instances
        for (int i = 0; i < 10; i++) begin
            go1(8'($urandom_range(0, 255)));
            go2(8'($urandom_range(0, 255)));
            tick(1);
            start1 = 1'b0;
            start2 = 1'b0;
            drain();
        end

        check("q1_empty", 32'(q1.size()), 32'd0);
        check("q2_empty", 32'(q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It performs one shift per clock, reusing a single bank of DIGITS add-3 cells rather than an unrolled combinational array. It sits between ALU/accumulator results and the seven-segment display drivers on the FPGA board. A start/done handshake lets the ALU result path launch conversions back-to-back.

Parameters:
WIDTH, 8, binary input width in bits (>=4)
DIGITS, 3, number of BCD output digits (>=1); DIGITS=ceil(WIDTH*log10(2)) guarantees no overflow
CNT_W, 4, width of the internal shift counter; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion of bin; sampled only when ready=1
bin  input  WIDTH  binary operand; captured on the accepting edge only
ready  output  1  high in IDLE and DONE states (start will be accepted)
busy  output  1  high in SHIFT state
done  output  1  one-cycle pulse: bcd/overflow updated this cycle
bcd  output  4*DIGITS  packed result, digit 0 (ones) in bits [3:0]
overflow  output  1  result exceeded 10**DIGITS-1; valid with bcd

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, scratch=0; outputs bcd=0, overflow=0, done=0, busy=0, ready=1.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge E -> load shift reg=bin, digit scratch=0, sticky ovf=0, counter=WIDTH. Go to SHIFT.
- SHIFT, each edge:
  - every scratch digit >=5 gets +3 (4-bit, no carry between digits);
  - then {scratch, shift reg} shifts left 1;
  - the bit leaving the top digit ORs into sticky ovf;
  - counter decrements.
- SHIFT exit: the edge where counter goes 1->0 performs the last shift, writes bcd<=scratch and overflow<=sticky ovf, and goes to DONE.
- Latency: start accepted at edge E -> last shift at edge E+WIDTH -> done=1 for the cycle after E+WIDTH. Throughput is one conversion per WIDTH+1 cycles.
- DONE (one cycle): done=1, ready=1.
  - start=1 at the next edge: reload exactly as from IDLE and go to SHIFT. Back-to-back conversions, no idle gap.
  - start=0: go to IDLE.
- start during SHIFT: ignored, no queuing. bin changes during SHIFT have no effect.
- bcd and overflow hold their last values until the next DONE. Intermediate scratch values are never visible on bcd.
- Overflow:
  - overflow=1 iff bin >= 10**DIGITS.
  - On overflow, bcd holds the low DIGITS digits of the true result; the upper digits are discarded.
- rst asserted mid-SHIFT: conversion aborted immediately, all reset values apply, no done pulse is issued.

Optional Feature:
BIN2BCD_SIGNED_EN
- Defined:
  - bin is two's complement.
  - At accept: magnitude = bin[WIDTH-1] ? -bin : bin, computed as WIDTH-bit unsigned so -2**(WIDTH-1) converts correctly.
  - Extra output port sign (1 bit, reset 0) is registered with bcd at DONE and is 1 for negative inputs.
  - Latency is unchanged.
- Undefined: bin is unsigned, the sign port does not exist, and no negation logic is built.

Test Plan:
- WIDTH=8, DIGITS=3, bin=8'd255, start pulsed at edge E -> done high the cycle after E+8, bcd=12'h255, overflow=0, ready low during SHIFT.
- bin=0, then bin=8'd9, then bin=8'd100, back-to-back with start held high -> bcd=12'h000, 12'h009, 12'h100, with done pulses 9 cycles apart.
- start pulsed with bin=8'd37, then start re-pulsed with bin=8'd200 during SHIFT -> single done with bcd=12'h037, second start ignored.
- WIDTH=8, DIGITS=2, bin=8'd123 -> overflow=1, bcd=8'h23. Then bin=8'd99 -> overflow=0, bcd=8'h99.
- rst asserted 3 cycles into a conversion of 8'd180 -> bcd=0, done never pulses, ready=1. A fresh start with bin=8'd180 then gives bcd=12'h180.
- BIN2BCD_SIGNED_EN defined, bin=8'h80 -> bcd=12'h128, sign=1. bin=8'hFF -> bcd=12'h001, sign=1. bin=8'd127 -> bcd=12'h127, sign=0.
